// File: rtl/spk_event_scanner_if.sv
// Spike scanner bus bundle: BRAM read/write port plus the outgoing event stream.
//
// Signals
//   ren, raddr       BRAM read request (data returns one cycle later on rdat)
//   rdat             BRAM read data
//   wren, wraddr,    BRAM write port, used only for clear-on-read
//   wrdat
//   evt_valid,       event stream toward the weight-fetch/accumulate stage
//   evt_ready,
//   evt_idx
//
// Modports
//   master  the scanner side (drives BRAM requests and events)
//   slave   the BRAM + consumer side
interface spk_event_scanner_if #(
  parameter int RAM_DEPTH      = 32,
  parameter int RAM_WIDTH      = 32,
  parameter int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int EVT_WIDTH      = $clog2(RAM_DEPTH * RAM_WIDTH)
) ();

  logic                      ren;
  logic [RAM_ADDR_WIDTH-1:0] raddr;
  logic [RAM_WIDTH-1:0]      rdat;
  logic                      wren;
  logic [RAM_ADDR_WIDTH-1:0] wraddr;
  logic [RAM_WIDTH-1:0]      wrdat;
  logic                      evt_valid;
  logic                      evt_ready;
  logic [EVT_WIDTH-1:0]      evt_idx;

  modport master (
    output ren, raddr, wren, wraddr, wrdat, evt_valid, evt_idx,
    input  rdat, evt_ready
  );

  modport slave (
    input  ren, raddr, wren, wraddr, wrdat, evt_valid, evt_idx,
    output rdat, evt_ready
  );

endinterface

// File: rtl/spk_event_scanner.sv
// Spike event scanner: once per timestep, reads the spike words of one layer
// from the spike BRAM and turns every set bit into a neuron-index event on a
// valid/ready stream, lowest index first. Counts handshaken events and pulses
// done when the scan finishes.
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset (aborts a scan immediately)
//   start      begin a scan; only looked at while idle
//   busy       scan in progress
//   done       one-cycle pulse at scan completion
//   spike_cnt  events accepted in the current / most recent scan
//   bus        BRAM port and event stream (spk_event_scanner_if.master)
//
// Build option
//   SPK_CLEAR_EN  when defined, each word is written back to zero as the scan
//                 leaves it, so the BRAM is empty for the next timestep.
//                 When undefined the write port is tied off.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// READ  | read request for word_ptr issued
// WAIT  | read data returning, captured into word_reg
// SCAN  | emit one event per set bit; leave when word_reg is empty
// DONE  | one-cycle done pulse
module spk_event_scanner #(
  parameter int RAM_DEPTH      = 32,
  parameter int RAM_WIDTH      = 32,
  parameter int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int NUM_WORDS      = RAM_DEPTH,
  parameter int EVT_WIDTH      = $clog2(RAM_DEPTH * RAM_WIDTH),
  parameter int CNT_WIDTH      = $clog2(RAM_DEPTH * RAM_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] spike_cnt,
  spk_event_scanner_if.master  bus
);

  localparam int BIT_W = (RAM_WIDTH > 1) ? $clog2(RAM_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SCAN = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0] word_ptr_q, word_ptr_d;
  logic [RAM_WIDTH-1:0]      word_reg_q, word_reg_d;
  logic [CNT_WIDTH-1:0]      spike_cnt_q, spike_cnt_d;

  logic [BIT_W-1:0]          low_idx;
  logic                      word_empty;
  logic                      last_word;

  logic                      ren;
  logic [RAM_ADDR_WIDTH-1:0] raddr;
  logic                      wren;
  logic [RAM_ADDR_WIDTH-1:0] wraddr;
  logic                      evt_valid;
  logic [EVT_WIDTH-1:0]      evt_idx;

  assign word_empty = (word_reg_q == '0);
  assign last_word  = (word_ptr_q == RAM_ADDR_WIDTH'(NUM_WORDS - 1));

  // Priority encoder for the lowest set bit; scanning downward lets the
  // lowest match win.
  always_comb begin
    low_idx = '0;
    for (int i = RAM_WIDTH - 1; i >= 0; i--) begin
      if (word_reg_q[i]) low_idx = BIT_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_ptr_q  <= '0;
      word_reg_q  <= '0;
      spike_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      word_ptr_q  <= word_ptr_d;
      word_reg_q  <= word_reg_d;
      spike_cnt_q <= spike_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    word_ptr_d  = word_ptr_q;
    word_reg_d  = word_reg_q;
    spike_cnt_d = spike_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          spike_cnt_d = '0;
          word_ptr_d  = '0;
          state_d     = READ;
        end
      end
      READ: state_d = WAIT;
      WAIT: begin
        word_reg_d = bus.rdat;
        state_d    = SCAN;
      end
      SCAN: begin
        if (!word_empty) begin
          if (bus.evt_ready) begin
            // x & (x-1) drops exactly the lowest set bit.
            word_reg_d  = word_reg_q & (word_reg_q - RAM_WIDTH'(1));
            spike_cnt_d = spike_cnt_q + CNT_WIDTH'(1);
          end
        end else if (last_word) begin
          state_d = DONE;
        end else begin
          word_ptr_d = word_ptr_q + RAM_ADDR_WIDTH'(1);
          state_d    = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ren       = 1'b0;
    raddr     = '0;
    wren      = 1'b0;
    wraddr    = '0;
    evt_valid = 1'b0;
    evt_idx   = '0;
    if (state_q == READ) begin
      ren   = 1'b1;
      raddr = word_ptr_q;
    end
    if (state_q == SCAN && !word_empty) begin
      evt_valid = 1'b1;
      evt_idx   = EVT_WIDTH'(word_ptr_q) * EVT_WIDTH'(RAM_WIDTH) + EVT_WIDTH'(low_idx);
    end
`ifdef SPK_CLEAR_EN
    if (state_q == SCAN && word_empty) begin
      wren   = 1'b1;
      wraddr = word_ptr_q;
    end
`endif
  end

  assign bus.ren       = ren;
  assign bus.raddr     = raddr;
  assign bus.wren      = wren;
  assign bus.wraddr    = wraddr;
  assign bus.wrdat     = '0;
  assign bus.evt_valid = evt_valid;
  assign bus.evt_idx   = evt_idx;

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign spike_cnt = spike_cnt_q;

endmodule

// File: tb/tb_spk_event_scanner.sv
module tb_spk_event_scanner;

  localparam int DEPTH = 32;
  localparam int WIDTH = 32;
  localparam int CW    = 11;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic [CW-1:0] spike_cnt;

  spk_event_scanner_if #(.RAM_DEPTH(DEPTH), .RAM_WIDTH(WIDTH)) bus ();

  spk_event_scanner #(.RAM_DEPTH(DEPTH), .RAM_WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .spike_cnt(spike_cnt),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // BRAM model and bus monitor
  logic [31:0] mem   [DEPTH];
  logic [31:0] stage [DEPTH];
  int load_cnt = 0, load_done = 0;
  logic rd_req = 1'b0;
  logic [4:0] rd_addr = '0;
  int ren_tot = 0, wren_tot = 0, done_tot = 0, valid_tot = 0;
  int hs_viol = 0, raddr_bad = 0, wr_bad = 0;
  logic stall_prev = 1'b0;
  logic [9:0] idx_prev = '0;
  int evq[$];
  int ralog[$];
  int exp_q[$];

  int rdy_mode = 0;
  logic rdy_man = 1'b0;

  always @(negedge clk) begin
    if (load_cnt != load_done) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = stage[i];
      load_done = load_cnt;
    end
    rd_req  = bus.ren;
    rd_addr = bus.raddr;
    if (bus.ren) begin
      ren_tot++;
      ralog.push_back(int'(bus.raddr));
    end else if (bus.raddr != 0) raddr_bad++;
    if (bus.wren) begin
      wren_tot++;
      if (bus.wrdat != 0) wr_bad++;
      mem[bus.wraddr] = bus.wrdat;
    end else if (bus.wraddr != 0 || bus.wrdat != 0) wr_bad++;
    if (done) done_tot++;
    if (bus.evt_valid) valid_tot++;
    if (!rst && stall_prev && !(bus.evt_valid && bus.evt_idx == idx_prev)) hs_viol++;
    stall_prev = bus.evt_valid && !bus.evt_ready && !rst;
    idx_prev   = bus.evt_idx;
    if (bus.evt_valid && bus.evt_ready) evq.push_back(int'(bus.evt_idx));
  end

  always @(posedge clk) bus.rdat <= rd_req ? mem[rd_addr] : 32'($urandom);

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       bus.evt_ready = 1'b1;
      1:       bus.evt_ready = 1'($urandom_range(0, 1));
      default: bus.evt_ready = rdy_man;
    endcase
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_stage();
    load_cnt++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Reference: every set bit of every word, in word order then bit order.
  task automatic build_model(input logic [31:0] img [DEPTH]);
    exp_q.delete();
    for (int w = 0; w < DEPTH; w++)
      for (int b = 0; b < WIDTH; b++)
        if (img[w][b]) exp_q.push_back(w * WIDTH + b);
  endtask

  task automatic run_scan(input int pulse_at, output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == pulse_at);
    end
    start = 1'b0;
    if (!done) chk("scan_timeout", done, 1);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
  endtask

  task automatic scan_and_check(input string tag, input int exp_cyc, input int pulse_at);
    int e0, r0, w0, d0, cyc, bad, n;
    logic [31:0] snap [DEPTH];
    e0 = evq.size(); r0 = ralog.size(); w0 = wren_tot; d0 = done_tot;
    snap = mem;
    build_model(snap);
    run_scan(pulse_at, cyc);
    if (exp_cyc > 0) chk({tag, " cycles"}, cyc, exp_cyc);
    chk({tag, " spike_cnt"}, spike_cnt, exp_q.size());
    n = evq.size() - e0;
    chk({tag, " evt_count"}, n, exp_q.size());
    bad = 0;
    for (int i = 0; i < n && i < exp_q.size(); i++) if (evq[e0 + i] != exp_q[i]) bad++;
    chk({tag, " evt_order"}, bad, 0);
    chk({tag, " ren_count"}, ralog.size() - r0, DEPTH);
    bad = 0;
    for (int i = 0; i < DEPTH && r0 + i < ralog.size(); i++) if (ralog[r0 + i] != i) bad++;
    chk({tag, " raddr_seq"}, bad, 0);
    chk({tag, " done_pulses"}, done_tot - d0, 1);
    bad = 0;
`ifdef SPK_CLEAR_EN
    chk({tag, " wren_count"}, wren_tot - w0, DEPTH);
    for (int i = 0; i < DEPTH; i++) if (mem[i] != 0) bad++;
`else
    chk({tag, " wren_count"}, wren_tot - w0, 0);
    for (int i = 0; i < DEPTH; i++) if (mem[i] != snap[i]) bad++;
`endif
    chk({tag, " mem_after"}, bad, 0);
    chk({tag, " hs_stable"}, hs_viol, 0);
    chk({tag, " raddr_idle"}, raddr_bad, 0);
    chk({tag, " wr_port"}, wr_bad, 0);
  endtask

  typedef struct {
    int          widx;
    logic [31:0] wval;
    int          exp_cnt;
    int          exp_cyc;
    int          first;
    int          last;
  } vec_t;

  vec_t vt [5];

  initial begin
    int e0, t, v0, cyc;
    vt[0] = '{widx: 0,  wval: 32'h0000_0005, exp_cnt: 2,  exp_cyc: 99,  first: 0,    last: 2};
    vt[1] = '{widx: 0,  wval: 32'h0000_0000, exp_cnt: 0,  exp_cyc: 97,  first: 0,    last: 0};
    vt[2] = '{widx: 3,  wval: 32'h8000_0001, exp_cnt: 2,  exp_cyc: 99,  first: 96,   last: 127};
    vt[3] = '{widx: 31, wval: 32'h8000_0000, exp_cnt: 1,  exp_cyc: 98,  first: 1023, last: 1023};
    vt[4] = '{widx: 5,  wval: 32'hFFFF_FFFF, exp_cnt: 32, exp_cyc: 129, first: 160,  last: 191};

    rst = 1'b1;
    start = 1'b1;
    for (int i = 0; i < DEPTH; i++) stage[i] = '0;
    load_cnt++;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("rst busy", busy, 0);
      chk("rst ren", bus.ren, 0);
      chk("rst evt_valid", bus.evt_valid, 0);
      chk("rst done", done, 0);
      chk("rst spike_cnt", spike_cnt, 0);
      chk("rst raddr_wren", {bus.raddr, bus.wren}, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    load_stage();

    // Table of single-word patterns with ready held high
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < DEPTH; i++) stage[i] = '0;
      stage[vt[v].widx] = vt[v].wval;
      load_stage();
      e0 = evq.size();
      v0 = valid_tot;
      scan_and_check($sformatf("vec%0d", v), vt[v].exp_cyc, 0);
      chk($sformatf("vec%0d cnt_const", v), spike_cnt, vt[v].exp_cnt);
      if (vt[v].exp_cnt > 0 && evq.size() > e0) begin
        chk($sformatf("vec%0d first_idx", v), evq[e0], vt[v].first);
        chk($sformatf("vec%0d last_idx", v), evq[evq.size() - 1], vt[v].last);
      end else begin
        chk($sformatf("vec%0d no_valid", v), valid_tot - v0, 0);
      end
`ifdef SPK_CLEAR_EN
      if (v == 4) scan_and_check("rescan_cleared", 97, 0);
`endif
    end

    // Backpressure: first event of word 3 held for 5 stalled cycles
    for (int i = 0; i < DEPTH; i++) stage[i] = '0;
    stage[3] = 32'h8000_0001;
    load_stage();
    rdy_man = 1'b0;
    rdy_mode = 2;
    e0 = evq.size();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t = 0;
    while (!bus.evt_valid && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("bp valid_seen", bus.evt_valid, 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp stall%0d valid", k), bus.evt_valid, 1);
      chk($sformatf("bp stall%0d idx", k), bus.evt_idx, 96);
      @(posedge clk);
      #1;
    end
    rdy_man = 1'b1;
    t = 0;
    while (!done && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("bp done_seen", done, 1);
    @(posedge clk);
    #1;
    chk("bp evt_count", evq.size() - e0, 2);
    if (evq.size() - e0 == 2) begin
      chk("bp evt0", evq[e0], 96);
      chk("bp evt1", evq[e0 + 1], 127);
    end
    chk("bp spike_cnt", spike_cnt, 2);
    chk("bp hs_stable", hs_viol, 0);
    rdy_mode = 0;

    // start pulsed mid-scan is ignored
    for (int i = 0; i < DEPTH; i++) stage[i] = '0;
    load_stage();
    scan_and_check("mid_start", 97, 40);

    // start during DONE ignored, accepted in the following IDLE cycle
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t = 0;
    while (!done && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("done_start seen", done, 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("done_start ignored", busy, 0);
    @(posedge clk);
    #1;
    chk("idle_start accepted", busy, 1);
    start = 1'b0;
    t = 0;
    while (!done && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("idle_start done", done, 1);
    @(posedge clk);
    #1;

    // Reset while an event is pending, then a fresh scan from word 0
    for (int i = 0; i < DEPTH; i++) stage[i] = '0;
    stage[0] = 32'h0000_0003;
    load_stage();
    rdy_man = 1'b0;
    rdy_mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t = 0;
    while (!bus.evt_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("abort valid_seen", bus.evt_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort evt_valid", bus.evt_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort ren", bus.ren, 0);
    chk("abort spike_cnt", spike_cnt, 0);
    rst = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    scan_and_check("after_abort", 99, 0);

    // Randomized sparse memories with random backpressure
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++)
        stage[i] = ($urandom_range(0, 2) == 0) ? ($urandom & $urandom) : 32'h0;
      load_stage();
      rdy_mode = 1;
      scan_and_check($sformatf("rand%0d", r), -1, 0);
      rdy_mode = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
